// File: rtl/intr_pkg.sv
// Shared register map and source-index helpers for the interrupt controller.
package intr_pkg;

  localparam logic [4:0] A_PENDING = 5'd0;
  localparam logic [4:0] A_SRC     = 5'd1;
  localparam logic [4:0] A_ENABLE  = 5'd2;
  localparam logic [4:0] A_MODE    = 5'd3;
  localparam logic [4:0] A_W1S     = 5'd4;
  localparam logic [4:0] A_W1C     = 5'd5;
  localparam logic [4:0] A_STATUS  = 5'd6;
  localparam logic [4:0] A_TCTRL   = 5'd7;
  localparam logic [4:0] A_TIMER0  = 5'd8;

  function automatic int swi_idx(input int nsrc);
    return nsrc;
  endfunction

  function automatic int timer_idx(input int nsrc, input int t);
    return nsrc + 1 + t;
  endfunction

  // Lowest set bit wins; an empty vector maps to 0.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/intr_timer.sv
// Countdown timer with reload; evt_o pulses combinationally while the count sits at 0 and run is set.
module intr_timer #(
  parameter int TW = 24
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ctrl_we_i,
  input  logic          run_wdata_i,
  input  logic          per_wdata_i,
  input  logic          cnt_lo_we_i,
  input  logic          cnt_hi_we_i,
  input  logic          rld_lo_we_i,
  input  logic          rld_hi_we_i,
  input  logic [15:0]   wdata_i,
  output logic [TW-1:0] count_o,
  output logic [TW-1:0] reload_o,
  output logic          run_o,
  output logic          periodic_o,
  output logic          evt_o
);

  logic [TW-1:0] count_q, count_d;
  logic [TW-1:0] reload_q, reload_d;
  logic          run_q, run_d;
  logic          per_q, per_d;
  logic          cnt_we;

  assign cnt_we = cnt_lo_we_i | cnt_hi_we_i;
  assign evt_o  = run_q & ~cnt_we & (count_q == '0);

  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    run_d    = run_q;
    per_d    = per_q;
    if (rld_lo_we_i) reload_d[15:0]    = wdata_i;
    if (rld_hi_we_i) reload_d[TW-1:16] = wdata_i[TW-17:0];
    if (cnt_we) begin
      if (cnt_lo_we_i) count_d[15:0]    = wdata_i;
      if (cnt_hi_we_i) count_d[TW-1:16] = wdata_i[TW-17:0];
    end else if (run_q) begin
      if (count_q == '0) begin
        if (per_q) count_d = reload_q;
        else       run_d   = 1'b0;
      end else begin
        count_d = count_q - TW'(1);
      end
    end
    // A software write to run overrides the one-shot self-clear.
    if (ctrl_we_i) begin
      run_d = run_wdata_i;
      per_d = per_wdata_i;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q  <= '0;
      reload_q <= '0;
      run_q    <= 1'b0;
      per_q    <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      run_q    <= run_d;
      per_q    <= per_d;
    end
  end

  assign count_o    = count_q;
  assign reload_o   = reload_q;
  assign run_o      = run_q;
  assign periodic_o = per_q;

endmodule

// File: rtl/intr_ctrl_p.sv
// Interrupt controller: external level/edge sources, a software bit and countdown timers,
// with registered interrupt/irq_id and a 16-bit register window.
module intr_ctrl_p #(
  parameter int NSRC   = 5,
  parameter int NTIMER = 2,
  parameter int TW     = 24
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NSRC-1:0] src,
  output logic            interrupt,
  output logic [3:0]      irq_id,
  input  logic            io_write,
  input  logic [4:0]      io_addr,
  input  logic [15:0]     io_wdata,
  output logic [15:0]     io_rdata
);
  import intr_pkg::*;

  localparam int N = NSRC + 1 + NTIMER;

  if (N > 16) begin : g_size_check
    $error("intr_ctrl_p: NSRC+1+NTIMER must not exceed 16");
  end

  logic [N-1:0]    enable_q, enable_d;
  logic [NSRC-1:0] mode_q, mode_d;
  logic [NSRC-1:0] src_q;
  logic [N-1:0]    latch_q, latch_d;
  logic            interrupt_q;
  logic [3:0]      irq_id_q;

  logic [N-1:0]    latchable_q, latchable_d;
  logic [N-1:0]    hw_set, s_vec, pending;
  logic [NTIMER-1:0] t_evt, t_run, t_per;
  logic [TW-1:0]   t_count  [NTIMER];
  logic [TW-1:0]   t_reload [NTIMER];

  assign latchable_q = {{(NTIMER+1){1'b1}}, mode_q};
  assign latchable_d = {{(NTIMER+1){1'b1}}, mode_d};
  assign s_vec       = (latch_q & latchable_q) | {{(NTIMER+1){1'b0}}, src & ~mode_q};
  assign pending     = s_vec & enable_q;

  for (genvar t = 0; t < NTIMER; t++) begin : g_timer
    localparam logic [4:0] BASE = 5'(8 + 4*t);
    intr_timer #(.TW(TW)) u_timer (
      .clk         (clk),
      .reset       (reset),
      .ctrl_we_i   (io_write && io_addr == A_TCTRL),
      .run_wdata_i (io_wdata[2*t]),
      .per_wdata_i (io_wdata[2*t+1]),
      .cnt_lo_we_i (io_write && io_addr == BASE),
      .cnt_hi_we_i (io_write && io_addr == BASE + 5'd1),
      .rld_lo_we_i (io_write && io_addr == BASE + 5'd2),
      .rld_hi_we_i (io_write && io_addr == BASE + 5'd3),
      .wdata_i     (io_wdata),
      .count_o     (t_count[t]),
      .reload_o    (t_reload[t]),
      .run_o       (t_run[t]),
      .periodic_o  (t_per[t]),
      .evt_o       (t_evt[t])
    );
  end

  always_comb begin
    hw_set = '0;
    hw_set[NSRC-1:0] = mode_q & src & ~src_q;
    for (int t = 0; t < NTIMER; t++) hw_set[timer_idx(NSRC, t)] = t_evt[t];
  end

  always_comb begin
    enable_d = enable_q;
    mode_d   = mode_q;
    latch_d  = latch_q;
    if (io_write && io_addr == A_ENABLE) enable_d = io_wdata[N-1:0];
    if (io_write && io_addr == A_MODE)   mode_d   = io_wdata[NSRC-1:0];
    if (io_write && io_addr == A_W1S)    latch_d  = latch_d | io_wdata[N-1:0];
    if (io_write && io_addr == A_W1C)    latch_d  = latch_d & ~io_wdata[N-1:0];
    // Hardware set is applied last so it beats a same-cycle clear; level bits stay empty.
    latch_d = (latch_d | hw_set) & latchable_d & (latchable_q | hw_set);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      enable_q    <= '0;
      mode_q      <= '0;
      src_q       <= '0;
      latch_q     <= '0;
      interrupt_q <= 1'b0;
      irq_id_q    <= '0;
    end else begin
      enable_q    <= enable_d;
      mode_q      <= mode_d;
      src_q       <= src;
      latch_q     <= latch_d;
      interrupt_q <= |pending;
      irq_id_q    <= lowest_set(16'(pending));
    end
  end

  assign interrupt = interrupt_q;
  assign irq_id    = irq_id_q;

  always_comb begin
    io_rdata = '0;
    case (io_addr)
      A_PENDING: io_rdata = 16'(pending);
      A_SRC:     io_rdata = 16'(s_vec);
      A_ENABLE:  io_rdata = 16'(enable_q);
      A_MODE:    io_rdata = 16'(mode_q);
      A_STATUS:  io_rdata = {interrupt_q, 11'b0, irq_id_q};
      A_TCTRL: begin
        for (int t = 0; t < NTIMER; t++) begin
          io_rdata[2*t]   = t_run[t];
          io_rdata[2*t+1] = t_per[t];
        end
      end
      default: begin
        for (int t = 0; t < NTIMER; t++) begin
          if (io_addr[4:2] == 3'(2 + t)) begin
            case (io_addr[1:0])
              2'd0:    io_rdata = t_count[t][15:0];
              2'd1:    io_rdata = 16'(t_count[t][TW-1:16]);
              2'd2:    io_rdata = t_reload[t][15:0];
              default: io_rdata = 16'(t_reload[t][TW-1:16]);
            endcase
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_intr_ctrl_p.sv
// Self-checking bench for intr_ctrl_p (default parameters): register table plus timer/edge/level/priority/reset sequences.
module tb_intr_ctrl_p;

  localparam int NSRC = 5, NTIMER = 2, TW = 24;

  logic            clk = 1'b0;
  logic            reset;
  logic [NSRC-1:0] src;
  logic            interrupt;
  logic [3:0]      irq_id;
  logic            io_write;
  logic [4:0]      io_addr;
  logic [15:0]     io_wdata;
  logic [15:0]     io_rdata;

  intr_ctrl_p #(.NSRC(NSRC), .NTIMER(NTIMER), .TW(TW)) dut (
    .clk(clk), .reset(reset), .src(src), .interrupt(interrupt), .irq_id(irq_id),
    .io_write(io_write), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [15:0] exp;
  } sb_t;

  typedef struct {
    logic        wr;
    logic [4:0]  waddr;
    logic [15:0] wdata;
    logic [4:0]  raddr;
    logic [15:0] exp;
    string       name;
  } vec_t;

  localparam int NV = 26;
  vec_t vt [NV];
  sb_t  sbq [$];
  int   checks = 0;
  int   errors = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [15:0] d);
    io_write = 1'b1; io_addr = a; io_wdata = d;
    tick();
    io_write = 1'b0;
  endtask

  task automatic expect_val(input string nm, input logic [15:0] e);
    sb_t s;
    s.name = nm; s.exp = e;
    sbq.push_back(s);
  endtask

  task automatic compare(input logic [15:0] act);
    sb_t s;
    checks++;
    if (sbq.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty: got %h with nothing expected", act);
    end else begin
      s = sbq.pop_front();
      if (act !== s.exp) begin
        errors++;
        $display("FAIL %s: got %h, expected %h", s.name, act, s.exp);
      end
    end
  endtask

  task automatic chk_rd(input logic [4:0] a, input logic [15:0] e, input string nm);
    expect_val(nm, e);
    io_addr = a;
    #1;
    compare(io_rdata);
  endtask

  task automatic chk_status(input logic [15:0] e, input string nm);
    expect_val(nm, e);
    compare({interrupt, 11'b0, irq_id});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    //        wr    waddr  wdata     raddr  exp
    vt[0]  = '{1'b0, 5'd0,  16'h0000, 5'd0,  16'h0000, "rst_pending"};
    vt[1]  = '{1'b0, 5'd0,  16'h0000, 5'd2,  16'h0000, "rst_enable"};
    vt[2]  = '{1'b0, 5'd0,  16'h0000, 5'd3,  16'h0000, "rst_mode"};
    vt[3]  = '{1'b0, 5'd0,  16'h0000, 5'd6,  16'h0000, "rst_status"};
    vt[4]  = '{1'b0, 5'd0,  16'h0000, 5'd7,  16'h0000, "rst_tctrl"};
    vt[5]  = '{1'b0, 5'd0,  16'h0000, 5'd8,  16'h0000, "rst_cnt0"};
    vt[6]  = '{1'b0, 5'd0,  16'h0000, 5'd13, 16'h0000, "rst_cnt1hi"};
    vt[7]  = '{1'b1, 5'd2,  16'hFFFF, 5'd2,  16'h00FF, "enable_mask"};
    vt[8]  = '{1'b1, 5'd3,  16'hFFFF, 5'd3,  16'h001F, "mode_mask"};
    vt[9]  = '{1'b1, 5'd3,  16'h0000, 5'd3,  16'h0000, "mode_clr"};
    vt[10] = '{1'b1, 5'd4,  16'h0020, 5'd1,  16'h0020, "swi_set"};
    vt[11] = '{1'b0, 5'd0,  16'h0000, 5'd6,  16'h8005, "swi_status"};
    vt[12] = '{1'b0, 5'd0,  16'h0000, 5'd0,  16'h0020, "swi_pending"};
    vt[13] = '{1'b1, 5'd4,  16'h0004, 5'd1,  16'h0020, "w1s_level_ignored"};
    vt[14] = '{1'b1, 5'd5,  16'h0020, 5'd1,  16'h0000, "swi_w1c"};
    vt[15] = '{1'b0, 5'd0,  16'h0000, 5'd6,  16'h0000, "status_cleared"};
    vt[16] = '{1'b1, 5'd8,  16'h1234, 5'd8,  16'h1234, "cnt0_lo"};
    vt[17] = '{1'b1, 5'd9,  16'hFFAB, 5'd9,  16'h00AB, "cnt0_hi_trunc"};
    vt[18] = '{1'b1, 5'd15, 16'hFFFF, 5'd15, 16'h00FF, "rld1_hi_trunc"};
    vt[19] = '{1'b1, 5'd14, 16'h5555, 5'd14, 16'h5555, "rld1_lo"};
    vt[20] = '{1'b1, 5'd7,  16'h000A, 5'd7,  16'h000A, "tctrl_periodic_only"};
    vt[21] = '{1'b0, 5'd0,  16'h0000, 5'd8,  16'h1234, "cnt_hold_stopped"};
    vt[22] = '{1'b0, 5'd0,  16'h0000, 5'd16, 16'h0000, "unmapped_zero"};
    vt[23] = '{1'b1, 5'd7,  16'h0000, 5'd7,  16'h0000, "tctrl_clr"};
    vt[24] = '{1'b1, 5'd8,  16'h0000, 5'd8,  16'h0000, "cnt0_lo_clr"};
    vt[25] = '{1'b1, 5'd9,  16'h0000, 5'd9,  16'h0000, "cnt0_hi_clr"};

    reset = 1'b1; src = '0; io_write = 1'b0; io_addr = '0; io_wdata = '0;
    repeat (3) tick();
    chk_status(16'h0000, "rst_ports");
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      if (vt[i].wr) wr(vt[i].waddr, vt[i].wdata);
      else          tick();
      chk_rd(vt[i].raddr, vt[i].exp, vt[i].name);
    end

    // One-shot timer 0: run written at edge E0, event at E4, interrupt at E5.
    wr(5'd2, 16'h0040);
    wr(5'd10, 16'd3); wr(5'd11, 16'd0);
    wr(5'd8, 16'd3);  wr(5'd9, 16'd0);
    wr(5'd7, 16'h0001);
    for (int k = 1; k <= 5; k++) begin
      tick();
      expect_val($sformatf("oneshot_int_k%0d", k), (k == 5) ? 16'd1 : 16'd0);
      compare({15'b0, interrupt});
    end
    chk_status(16'h8006, "oneshot_status");
    chk_rd(5'd7, 16'h0000, "oneshot_run_selfclr");
    chk_rd(5'd8, 16'h0000, "oneshot_cnt_zero");
    wr(5'd5, 16'h0040);
    chk_rd(5'd1, 16'h0000, "oneshot_w1c");
    repeat (5) tick();
    chk_rd(5'd1, 16'h0000, "oneshot_no_refire");

    // Periodic timer 0 with reload 9: events at E10, E20, ...
    wr(5'd10, 16'd9);
    wr(5'd8, 16'd9);
    wr(5'd7, 16'h0003);
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk_rd(5'd1, (k == 10) ? 16'h0040 : 16'h0000, $sformatf("periodic_k%0d", k));
    end
    wr(5'd5, 16'h0040);
    chk_rd(5'd1, 16'h0000, "periodic_w1c");
    repeat (8) tick();
    chk_rd(5'd1, 16'h0000, "periodic_before_evt");
    wr(5'd5, 16'h0040);
    chk_rd(5'd1, 16'h0040, "periodic_set_beats_clr");
    chk_rd(5'd8, 16'd9, "periodic_reloaded");
    wr(5'd7, 16'h0000);
    wr(5'd5, 16'h0040);
    chk_rd(5'd1, 16'h0000, "periodic_stop_clr");

    // Edge mode on src[2].
    wr(5'd2, 16'h00FF);
    wr(5'd3, 16'h0004);
    src = 5'b00100;
    tick();
    src = '0;
    chk_rd(5'd1, 16'h0004, "edge_latched");
    tick(); tick();
    chk_rd(5'd1, 16'h0004, "edge_hold");
    chk_status(16'h8002, "edge_status");
    wr(5'd5, 16'h0004);
    chk_rd(5'd1, 16'h0000, "edge_w1c");

    // Level mode on src[2].
    wr(5'd3, 16'h0000);
    src = 5'b00100;
    #1;
    chk_rd(5'd1, 16'h0004, "level_follow");
    wr(5'd5, 16'h0004);
    chk_rd(5'd1, 16'h0004, "level_w1c_ignored");
    src = '0;
    #1;
    chk_rd(5'd1, 16'h0000, "level_drop");

    // Priority: src[3] beats swi; disabling bit 3 hands over to swi.
    src = 5'b01000;
    wr(5'd4, 16'h0020);
    tick();
    chk_status(16'h8003, "prio_src3");
    wr(5'd2, 16'h00F7);
    tick();
    chk_status(16'h8005, "prio_swi_after_disable");
    src = '0;
    wr(5'd5, 16'h0020);

    // Reset during a one-shot count of 100.
    wr(5'd2, 16'h0040);
    wr(5'd8, 16'd100);
    wr(5'd7, 16'h0001);
    repeat (5) tick();
    chk_rd(5'd8, 16'd95, "pre_reset_count");
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk_rd(5'd8, 16'h0000, "reset_cnt");
    chk_rd(5'd7, 16'h0000, "reset_tctrl");
    chk_status(16'h0000, "reset_status");
    repeat (110) tick();
    chk_rd(5'd1, 16'h0000, "reset_no_event");
    chk_status(16'h0000, "reset_no_interrupt");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/intr_ctrl_p.md
INTR_CTRL_P -- requirements
Module: intr_ctrl_p

Interface
REQ-001 SHALL have parameter NSRC, default 5, giving the number of external interrupt inputs (1..11).
REQ-002 SHALL have parameter NTIMER, default 2, giving the number of countdown timers (1..4).
REQ-003 SHALL have parameter TW, default 24, giving the timer width in bits (17..32).
REQ-004 SHALL have port clk, input, 1 bit: clock.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port src, input, NSRC bits: external interrupt requests, synchronous to clk.
REQ-007 SHALL have port interrupt, output, 1 bit: registered OR of all enabled pending sources.
REQ-008 SHALL have port irq_id, output, 4 bits: registered index of the highest-priority enabled pending source.
REQ-009 SHALL have port io_write, input, 1 bit: register write strobe.
REQ-010 SHALL have port io_addr, input, 5 bits: register address.
REQ-011 SHALL have port io_wdata, input, 16 bits: write data.
REQ-012 SHALL have port io_rdata, output, 16 bits: combinational read data for io_addr.

Function
REQ-013 SHALL form a source vector S of N = NSRC+1+NTIMER bits, with N ≤ 16: bits [NSRC-1:0] external, bit NSRC swi, bits NSRC+1+t timer t.
REQ-014 SHALL treat external source i as level (S[i]=src[i]) when mode[i]=0, and as edge when mode[i]=1 (a latch set on src[i] rising versus its registered previous value).
REQ-015 SHALL always latch the swi and timer sources.
REQ-016 SHALL let a hardware set of a latch win over a same-cycle software clear.
REQ-017 SHALL define pending = S & enable.
REQ-018 SHALL register interrupt as |pending one cycle after the cause.
REQ-019 SHALL register irq_id as the lowest set index of pending (lowest index is highest priority), and 0 when none is pending.
REQ-020 SHALL implement this register map (upper bits read 0):
- 0 pending, RO.
- 1 S, RO.
- 2 enable, RW.
- 3 mode[NSRC-1:0], RW.
- 4 W1S on latches.
- 5 W1C on latches.
- 6 RO: {interrupt, 11'b0, irq_id}.
- 7 timer control, RW: bit 2t = run, bit 2t+1 = periodic.
- 8+4t count lo; 9+4t count hi; 10+4t reload lo; 11+4t reload hi.
REQ-021 SHALL make W1S/W1C writes to level-mode bits have no effect.
REQ-022 SHALL apply register writes on the clock edge, visible on the next cycle.
REQ-023 SHALL update timer t as follows when run=1, in priority order:
- a write to its count half loads that half;
- else count==0 sets the timer latch, then reloads when periodic=1, or clears run and holds 0 when periodic=0;
- else count decrements by 1.
REQ-024 SHALL hold the timer count when run=0, and SHALL raise no event.
REQ-025 SHALL truncate the hi-half writes and reads to TW-16 bits.
REQ-026 SHALL apply the reload value unchanged, with no off-by-one: the period is reload+1 cycles.
REQ-027 SHALL treat reload=0 with periodic=1 as an event on every cycle.
REQ-028 SHALL give a software write to run the priority over the one-shot self-clear in the same cycle.

Reset
REQ-029 SHALL clear the following on reset: enable, mode, all latches, the src history, timer counts, reloads and control, interrupt, and irq_id (all to 0).
REQ-030 SHALL abandon a timer run in progress when reset is asserted mid-count, raising no event.

Structure
REQ-031 SHALL place the register address constants and source-index offset functions in a shared package, intr_pkg.
REQ-032 SHALL implement one timer as sub-module intr_timer (parameter TW), instantiated NTIMER times by generate.
REQ-033 SHALL elaborate-time check that N ≤ 16.

Verification
REQ-034 SHALL cover a one-shot timer: reload=3, count=3, periodic=0, run=1, enable timer0 -> interrupt rises 5 cycles after the run write, irq_id = NSRC+1, run reads 0.
REQ-035 SHALL cover a periodic timer: reload=9, periodic=1 -> a latch set every 10 cycles; W1C clears it, and a clear coinciding with an event leaves the bit set.
REQ-036 SHALL cover edge mode: mode[2]=1, src[2] pulsed for 1 cycle -> S[2] stays 1 after src drops until a W1C of 0x0004.
REQ-037 SHALL cover level mode: src[2] held with mode[2]=0 -> a W1C has no effect, and S[2] follows src.
REQ-038 SHALL cover priority: src[3] and swi both pending and enabled -> irq_id=3; clearing enable bit 3 -> irq_id = NSRC the next cycle.
REQ-039 SHALL cover reset mid-count: reset during count=100 -> count=0, interrupt=0, and no event after release.
